// File: rtl/cell_bist_ctrl.sv
// cell_bist_ctrl: exhaustive BIST sequencer for a single combinational library cell.
// Each pattern is applied to the cell, held for SETTLE cycles, then the cell output
// is compared with the expected truth table TT. Results are kept as sticky
// pass/fail flags, a per-pattern failure map and a saturating error count.
// Optional build macro CELL_BIST_STOP_ON_FAIL_EN: the first mismatch ends the run
// at once, leaving drv on the failing pattern.
module cell_bist_ctrl #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] TT     = 4'b0001,
  parameter int                   SETTLE = 2,
  parameter int                   ITER   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        drv,
  input  logic                   obs,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [(1<<N_IN)-1:0]   fail_vec,
  output logic [7:0]             err_cnt
);

  localparam int NP = 1 << N_IN;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state_r, next_s;
  logic [N_IN-1:0] pat_r, pat_s;
  logic [7:0]      iter_r, iter_s;
  logic [3:0]      cnt_r, cnt_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            pass_r, pass_s;
  logic            fail_r, fail_s;
  logic [NP-1:0]   fvec_r, fvec_s;
  logic [7:0]      err_r, err_s;
  logic            mismatch_s, last_pat_s, last_iter_s, sat_s;

  // Decode the compare result and the end-of-sweep / end-of-run conditions.
  always_comb begin
    mismatch_s  = (state_r == ST_SAMPLE) && (obs != TT[pat_r]);
    last_pat_s  = (pat_r == {N_IN{1'b1}});
    last_iter_s = (iter_r == 8'(ITER - 1));
    sat_s       = (err_r == 8'hFF);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic of the sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_s = ST_APPLY;
        else       next_s = ST_IDLE;
      end
      ST_APPLY: begin
        if (SETTLE != 0) next_s = ST_SETTLE;
        else             next_s = ST_SAMPLE;
      end
      ST_SETTLE: begin
        if (cnt_r == 4'd0) next_s = ST_SAMPLE;
        else               next_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        if (mismatch_s)        next_s = ST_DONE;
        else if (!last_pat_s)  next_s = ST_APPLY;
        else if (!last_iter_s) next_s = ST_APPLY;
        else                   next_s = ST_DONE;
`else
        if (!last_pat_s)       next_s = ST_APPLY;
        else if (!last_iter_s) next_s = ST_APPLY;
        else                   next_s = ST_DONE;
`endif
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Next values of counters and result flags, keyed on the current state and transition.
  always_comb begin
    pat_s  = pat_r;
    iter_s = iter_r;
    cnt_s  = cnt_r;
    busy_s = busy_r;
    done_s = done_r;
    pass_s = pass_r;
    fail_s = fail_r;
    fvec_s = fvec_r;
    err_s  = err_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pat_s  = {N_IN{1'b0}};
          iter_s = 8'd0;
          busy_s = 1'b1;
          done_s = 1'b0;
          pass_s = 1'b0;
          fail_s = 1'b0;
          fvec_s = {NP{1'b0}};
          err_s  = 8'd0;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_APPLY: begin
        if (SETTLE != 0) cnt_s = 4'(SETTLE - 1);
        else             cnt_s = 4'd0;
      end
      ST_SETTLE: begin
        if (cnt_r != 4'd0) cnt_s = cnt_r - 4'd1;
        else               cnt_s = 4'd0;
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          fvec_s[pat_r] = 1'b1;
          fail_s        = 1'b1;
          if (!sat_s) err_s = err_r + 8'd1;
          else        err_s = err_r;
        end else begin
          fvec_s = fvec_r;
        end
        if (next_s == ST_APPLY) begin
          if (!last_pat_s) begin
            pat_s = pat_r + N_IN'(1);
          end else begin
            pat_s  = {N_IN{1'b0}};
            iter_s = iter_r + 8'd1;
          end
        end else if (next_s == ST_DONE) begin
          // pass reflects the whole run, including this final compare.
          done_s = 1'b1;
          pass_s = !fail_s;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r  <= {N_IN{1'b0}};
      iter_r <= 8'd0;
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      fvec_r <= {NP{1'b0}};
      err_r  <= 8'd0;
    end else begin
      pat_r  <= pat_s;
      iter_r <= iter_s;
      cnt_r  <= cnt_s;
      busy_r <= busy_s;
      done_r <= done_s;
      pass_r <= pass_s;
      fail_r <= fail_s;
      fvec_r <= fvec_s;
      err_r  <= err_s;
    end
  end

  assign drv      = pat_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign fail     = fail_r;
  assign fail_vec = fvec_r;
  assign err_cnt  = err_r;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Directed self-checking bench for cell_bist_ctrl. Four instances cover the default
// configuration, ITER=3, SETTLE=0 and ITER=100; each has its own modelled cell output.
module tb_cell_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance A: defaults, NOR model with optional fault on pattern 2.
  logic start_a = 1'b0, obs_a, busy_a, done_a, pass_a, fail_a;
  logic [1:0] drv_a; logic [3:0] fvec_a; logic [7:0] err_a;
  int mode_a = 0;
  assign obs_a = (mode_a == 1 && drv_a == 2'd2) ? 1'b1 : ~|drv_a;

  // Instance B: ITER=3, output stuck at 0.
  logic start_b = 1'b0, obs_b, busy_b, done_b, pass_b, fail_b;
  logic [1:0] drv_b; logic [3:0] fvec_b; logic [7:0] err_b;
  assign obs_b = 1'b0;

  // Instance C: SETTLE=0, ideal NOR.
  logic start_c = 1'b0, obs_c, busy_c, done_c, pass_c, fail_c;
  logic [1:0] drv_c; logic [3:0] fvec_c; logic [7:0] err_c;
  assign obs_c = ~|drv_c;

  // Instance D: ITER=100, inverted NOR (always wrong).
  logic start_d = 1'b0, obs_d, busy_d, done_d, pass_d, fail_d;
  logic [1:0] drv_d; logic [3:0] fvec_d; logic [7:0] err_d;
  assign obs_d = |drv_d;

  cell_bist_ctrl u_a (.clk(clk), .rst(rst), .start(start_a), .drv(drv_a), .obs(obs_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a), .fail_vec(fvec_a), .err_cnt(err_a));
  cell_bist_ctrl #(.ITER(3)) u_b (.clk(clk), .rst(rst), .start(start_b), .drv(drv_b), .obs(obs_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b), .fail_vec(fvec_b), .err_cnt(err_b));
  cell_bist_ctrl #(.SETTLE(0)) u_c (.clk(clk), .rst(rst), .start(start_c), .drv(drv_c), .obs(obs_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c), .fail_vec(fvec_c), .err_cnt(err_c));
  cell_bist_ctrl #(.ITER(100)) u_d (.clk(clk), .rst(rst), .start(start_d), .drv(drv_d), .obs(obs_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .fail(fail_d), .fail_vec(fvec_d), .err_cnt(err_d));

  // Pulse start for one edge (edge k); returns #1 after edge k.
  task automatic kick(input int sel);
    @(negedge clk);
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      2: start_c = 1'b1;
      default: start_d = 1'b1;
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({drv_a, busy_a, done_a, pass_a, fail_a, fvec_a, err_a} !== 18'd0) begin
      n_err++; $display("FAIL reset_a: got %h want 0", {drv_a, busy_a, done_a, pass_a, fail_a, fvec_a, err_a}); end
    n_cmp++; if ({drv_b, busy_b, done_b, pass_b, fail_b, fvec_b, err_b} !== 18'd0) begin
      n_err++; $display("FAIL reset_b: got %h want 0", {drv_b, busy_b, done_b, pass_b, fail_b, fvec_b, err_b}); end
    n_cmp++; if ({drv_c, busy_c, done_c, pass_c, fail_c, fvec_c, err_c} !== 18'd0) begin
      n_err++; $display("FAIL reset_c: got %h want 0", {drv_c, busy_c, done_c, pass_c, fail_c, fvec_c, err_c}); end
    n_cmp++; if ({drv_d, busy_d, done_d, pass_d, fail_d, fvec_d, err_d} !== 18'd0) begin
      n_err++; $display("FAIL reset_d: got %h want 0", {drv_d, busy_d, done_d, pass_d, fail_d, fvec_d, err_d}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nor_pass;
    logic [1:0] exp_drv;
    mode_a = 0;
    kick(0);
    n_cmp++; if (busy_a !== 1'b1 || drv_a !== 2'd0 || done_a !== 1'b0) begin
      n_err++; $display("FAIL pass_accept: got busy=%b drv=%0d done=%b want 1 0 0", busy_a, drv_a, done_a); end
    for (int j = 1; j <= 17; j++) begin
      @(posedge clk); #1;
      exp_drv = (j >= 16) ? 2'd3 : 2'(j / 4);
      n_cmp++; if (drv_a !== exp_drv) begin
        n_err++; $display("FAIL pass_drv j=%0d: got %0d want %0d", j, drv_a, exp_drv); end
      n_cmp++; if (done_a !== (j == 16)) begin
        n_err++; $display("FAIL pass_done j=%0d: got %b want %b", j, done_a, (j == 16)); end
      n_cmp++; if (busy_a !== (j <= 16)) begin
        n_err++; $display("FAIL pass_busy j=%0d: got %b want %b", j, busy_a, (j <= 16)); end
    end
    n_cmp++; if ({pass_a, fail_a, fvec_a, err_a} !== {1'b1, 1'b0, 4'b0000, 8'd0}) begin
      n_err++; $display("FAIL pass_result: got pass=%b fail=%b fvec=%b err=%0d want 1 0 0000 0",
                        pass_a, fail_a, fvec_a, err_a); end
  endtask

  task automatic test_fail_pattern2;
    int d;
    logic [1:0] exp_drv;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
    d = 12; exp_drv = 2'd2;
`else
    d = 16; exp_drv = 2'd3;
`endif
    mode_a = 1;
    kick(0);
    n_cmp++; if (pass_a !== 1'b0) begin
      n_err++; $display("FAIL f2_pass_cleared: got %b want 0", pass_a); end
    for (int j = 1; j <= d + 1; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (done_a !== (j == d)) begin
        n_err++; $display("FAIL f2_done j=%0d: got %b want %b", j, done_a, (j == d)); end
      if (j == 11) begin
        n_cmp++; if (fail_a !== 1'b0) begin
          n_err++; $display("FAIL f2_fail_early: got %b want 0", fail_a); end
      end
      if (j == 12) begin
        n_cmp++; if (fail_a !== 1'b1) begin
          n_err++; $display("FAIL f2_fail_rise: got %b want 1", fail_a); end
      end
      if (j == d) begin
        n_cmp++; if ({pass_a, fail_a, fvec_a, err_a} !== {1'b0, 1'b1, 4'b0100, 8'd1}) begin
          n_err++; $display("FAIL f2_result: got pass=%b fail=%b fvec=%b err=%0d want 0 1 0100 1",
                            pass_a, fail_a, fvec_a, err_a); end
        n_cmp++; if (drv_a !== exp_drv) begin
          n_err++; $display("FAIL f2_drv: got %0d want %0d", drv_a, exp_drv); end
      end
    end
    n_cmp++; if (busy_a !== 1'b0 || fail_a !== 1'b1 || pass_a !== 1'b0) begin
      n_err++; $display("FAIL f2_idle: got busy=%b fail=%b pass=%b want 0 1 0", busy_a, fail_a, pass_a); end
    mode_a = 0;
  endtask

  task automatic test_iter3_stuck0;
    int d;
    logic [7:0] exp_err;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
    d = 4; exp_err = 8'd1;
`else
    d = 48; exp_err = 8'd3;
`endif
    kick(1);
    for (int j = 1; j <= d + 1; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (done_b !== (j == d)) begin
        n_err++; $display("FAIL it3_done j=%0d: got %b want %b", j, done_b, (j == d)); end
      if (j == 20 && d > 20) begin
        n_cmp++; if (err_b !== 8'd2) begin
          n_err++; $display("FAIL it3_err_mid: got %0d want 2", err_b); end
      end
    end
    n_cmp++; if ({pass_b, fail_b, fvec_b, err_b} !== {1'b0, 1'b1, 4'b0001, exp_err}) begin
      n_err++; $display("FAIL it3_result: got pass=%b fail=%b fvec=%b err=%0d want 0 1 0001 %0d",
                        pass_b, fail_b, fvec_b, err_b, exp_err); end
  endtask

  task automatic test_settle0_busy_start;
    logic [1:0] exp_drv;
    kick(2);
    for (int j = 1; j <= 11; j++) begin
      @(posedge clk); #1;
      exp_drv = (j >= 8) ? 2'd3 : 2'(j / 2);
      n_cmp++; if (drv_c !== exp_drv) begin
        n_err++; $display("FAIL s0_drv j=%0d: got %0d want %0d", j, drv_c, exp_drv); end
      n_cmp++; if (done_c !== (j == 8)) begin
        n_err++; $display("FAIL s0_done j=%0d: got %b want %b", j, done_c, (j == 8)); end
      n_cmp++; if (busy_c !== (j <= 8)) begin
        n_err++; $display("FAIL s0_busy j=%0d: got %b want %b", j, busy_c, (j <= 8)); end
      // start high at edge k+4 (busy) and at edge k+9 (DONE): both must be ignored
      start_c = (j == 3 || j == 8);
    end
    start_c = 1'b0;
    n_cmp++; if ({pass_c, fail_c, fvec_c, err_c} !== {1'b1, 1'b0, 4'b0000, 8'd0}) begin
      n_err++; $display("FAIL s0_result: got pass=%b fail=%b fvec=%b err=%0d want 1 0 0000 0",
                        pass_c, fail_c, fvec_c, err_c); end
  endtask

  task automatic test_reset_midrun;
    mode_a = 1;
    kick(0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (busy_a !== 1'b1 || drv_a !== 2'd1) begin
      n_err++; $display("FAIL rm_before: got busy=%b drv=%0d want 1 1", busy_a, drv_a); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({drv_a, busy_a, done_a, pass_a, fail_a, fvec_a, err_a} !== 18'd0) begin
      n_err++; $display("FAIL rm_clear: got %h want 0", {drv_a, busy_a, done_a, pass_a, fail_a, fvec_a, err_a}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_err++; $display("FAIL rm_quiet j=%0d: got done=%b busy=%b want 0 0", j, done_a, busy_a); end
    end
    mode_a = 0;
    kick(0);
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (done_a !== (j == 16)) begin
        n_err++; $display("FAIL rm_rerun_done j=%0d: got %b want %b", j, done_a, (j == 16)); end
    end
    n_cmp++; if ({pass_a, fail_a, fvec_a, err_a} !== {1'b1, 1'b0, 4'b0000, 8'd0}) begin
      n_err++; $display("FAIL rm_rerun_result: got pass=%b fail=%b fvec=%b err=%0d want 1 0 0000 0",
                        pass_a, fail_a, fvec_a, err_a); end
  endtask

  task automatic test_saturate;
    int d, j, seen;
    logic [3:0] exp_fvec;
    logic [7:0] exp_err;
`ifdef CELL_BIST_STOP_ON_FAIL_EN
    d = 4; exp_fvec = 4'b0001; exp_err = 8'd1;
`else
    d = 1600; exp_fvec = 4'b1111; exp_err = 8'd255;
`endif
    kick(3);
    j = 0; seen = 0;
    while (seen == 0 && j < 2000) begin
      @(posedge clk); #1;
      j++;
      if (done_d) seen = j;
    end
    n_cmp++; if (seen != d) begin
      n_err++; $display("FAIL sat_done_edge: got %0d want %0d", seen, d); end
    n_cmp++; if ({pass_d, fail_d, fvec_d, err_d} !== {1'b0, 1'b1, exp_fvec, exp_err}) begin
      n_err++; $display("FAIL sat_result: got pass=%b fail=%b fvec=%b err=%0d want 0 1 %b %0d",
                        pass_d, fail_d, fvec_d, err_d, exp_fvec, exp_err); end
    @(posedge clk); #1;
    n_cmp++; if (busy_d !== 1'b0 || done_d !== 1'b0) begin
      n_err++; $display("FAIL sat_idle: got busy=%b done=%b want 0 0", busy_d, done_d); end
  endtask

  initial begin
    test_reset;
    test_nor_pass;
    test_fail_pattern2;
    test_iter3_stuck0;
    test_settle0_busy_start;
    test_reset_midrun;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
